rj45_status_reader: RTL and testbench

Serial-in, parallel-out reader for a daisy-chain of 74HC165-style parallel-load shift registers carrying RJ45 link/status inputs. It is the receive-side counterpart of the RJ45 LED shift-out driver. It runs from `sys_clk` and generates the register load and shift clock. It shifts in `N_BITS` status bits and presents them as a parallel word with a one-cycle valid strobe, for capture into a FrontPanel-visible register.

---
 rtl/rj45_status_reader.sv | 156 +++++++++++++++
 tb/tb_rj45_status_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rj45_status_reader.sv
// Serial-in/parallel-out reader for a daisy chain of 74HC165-style registers.
// Generates SH/LD, CLK INH and shift clock; delivers an MSB-first word with a valid strobe.
`timescale 1ns/1ps
module rj45_status_reader #(
  parameter int N_BITS  = 8,
  parameter int CLK_DIV = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              read_request,
  input  logic              shreg_sout,
  output logic              shreg_sck,
  output logic              shreg_load_n,
  output logic              shreg_ce_n,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic [15:0]       read_count
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [N_BITS-1:0]   sr_q, sr_d;
  logic [N_BITS-1:0]   data_q, data_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          sync_q;
  logic                sck_q, sck_d;
  logic                load_n_q, load_n_d;
  logic                ce_n_q, ce_n_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                phase_last;

  assign phase_last = (phase_q == PW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (read_request) state_d = LOAD;
      end
      LOAD: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = SETTLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SETTLE: begin
        if (phase_last) begin
          phase_d = '0;
          bit_d   = '0;
          state_d = SHIFT_LO;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_LO: begin
        // Sample at the end of the low phase, well after the previous sck rise.
        if (phase_last) begin
          phase_d = '0;
          sr_d    = {sr_q[N_BITS-2:0], sync_q[1]};
          state_d = (bit_q == BW'(N_BITS - 1)) ? DONE : SHIFT_HI;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_last) begin
          phase_d = '0;
          bit_d   = bit_q + BW'(1);
          state_d = SHIFT_LO;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE: begin
        phase_d = '0;
        data_d  = sr_q;
        count_d = count_q + 16'd1;
        state_d = read_request ? LOAD : IDLE;
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    sck_d    = (state_d == SHIFT_HI);
    load_n_d = (state_d != LOAD);
    ce_n_d   = !((state_d == SETTLE) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI));
    busy_d   = (state_d != IDLE);
    valid_d  = (state_q == DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      data_q   <= '0;
      count_q  <= '0;
      sync_q   <= '0;
      sck_q    <= 1'b0;
      load_n_q <= 1'b1;
      ce_n_q   <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      data_q   <= data_d;
      count_q  <= count_d;
      sync_q   <= {sync_q[0], shreg_sout};
      sck_q    <= sck_d;
      load_n_q <= load_n_d;
      ce_n_q   <= ce_n_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign shreg_sck    = sck_q;
  assign shreg_load_n = load_n_q;
  assign shreg_ce_n   = ce_n_q;
  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign busy         = busy_q;
  assign read_count   = count_q;

endmodule

// File: tb/tb_rj45_status_reader.sv
// Testbench for rj45_status_reader: three instances (8/16, 8/4, 16/4), each
// driving a behavioural 74HC165 chain model, checked against hand-computed values.
`timescale 1ns/1ps
module tb_rj45_status_reader;

   logic sys_clk = 1'b0;
   logic reset = 1'b1;

   // Instance A: defaults (N_BITS=8, CLK_DIV=16)
   logic        reqA = 1'b0;
   logic [7:0]  parA = '0;
   logic [7:0]  chainA = '0;
   logic        sckA, loadNA, ceNA, validA, busyA, prevSckA = 1'b0;
   logic [7:0]  doutA;
   logic [15:0] cntA;

   // Instance B: N_BITS=8, CLK_DIV=4
   logic        reqB = 1'b0;
   logic [7:0]  parB = '0;
   logic [7:0]  chainB = '0;
   logic        sckB, loadNB, ceNB, validB, busyB, prevSckB = 1'b0;
   logic [7:0]  doutB;
   logic [15:0] cntB;

   // Instance C: N_BITS=16, CLK_DIV=4
   logic        reqC = 1'b0;
   logic [15:0] parC = '0;
   logic [15:0] chainC = '0;
   logic        sckC, loadNC, ceNC, validC, busyC, prevSckC = 1'b0;
   logic [15:0] doutC;
   logic [15:0] cntC;

   int cyc = 0;
   int sckRisesA = 0, loadLowsA = 0;
   int sckRisesC = 0;
   int loadLowsB = 0, strobesB = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic [7:0]  pattern;
      logic [7:0]  expData;
      logic [15:0] expCount;
   } vec_t;

   vec_t vecs[5];

   rj45_status_reader #(.N_BITS(8), .CLK_DIV(16)) dutA (
      .sys_clk(sys_clk), .reset(reset), .read_request(reqA), .shreg_sout(chainA[7]),
      .shreg_sck(sckA), .shreg_load_n(loadNA), .shreg_ce_n(ceNA), .data_out(doutA),
      .data_valid(validA), .busy(busyA), .read_count(cntA));

   rj45_status_reader #(.N_BITS(8), .CLK_DIV(4)) dutB (
      .sys_clk(sys_clk), .reset(reset), .read_request(reqB), .shreg_sout(chainB[7]),
      .shreg_sck(sckB), .shreg_load_n(loadNB), .shreg_ce_n(ceNB), .data_out(doutB),
      .data_valid(validB), .busy(busyB), .read_count(cntB));

   rj45_status_reader #(.N_BITS(16), .CLK_DIV(4)) dutC (
      .sys_clk(sys_clk), .reset(reset), .read_request(reqC), .shreg_sout(chainC[15]),
      .shreg_sck(sckC), .shreg_load_n(loadNC), .shreg_ce_n(ceNC), .data_out(doutC),
      .data_valid(validC), .busy(busyC), .read_count(cntC));

   // 100 MHz system clock
   always #5 sys_clk = ~sys_clk;

   // Behavioural shift-register chains plus free-running event counters.
   // A chain loads its parallel inputs while SH/LD is low and shifts toward QH
   // one clock after each sck rise while CLK INH is low.
   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      prevSckA <= sckA;
      prevSckB <= sckB;
      prevSckC <= sckC;
      if (!loadNA) chainA <= parA;
      else if (!ceNA && sckA && !prevSckA) chainA <= {chainA[6:0], 1'b0};
      if (!loadNB) chainB <= parB;
      else if (!ceNB && sckB && !prevSckB) chainB <= {chainB[6:0], 1'b0};
      if (!loadNC) chainC <= parC;
      else if (!ceNC && sckC && !prevSckC) chainC <= {chainC[14:0], 1'b0};
      if (sckA && !prevSckA) sckRisesA <= sckRisesA + 1;
      if (sckC && !prevSckC) sckRisesC <= sckRisesC + 1;
      if (!loadNA) loadLowsA <= loadLowsA + 1;
      if (!loadNB) loadLowsB <= loadLowsB + 1;
      if (validB) strobesB <= strobesB + 1;
   end

   // Compare one observed value against its expected value and tally the result
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Pulse read_request for exactly one sampling edge; returns the cycle stamp of that edge
   task automatic applyStimulus(input int which, input logic [15:0] pattern, output int kCyc);
      @(negedge sys_clk);
      case (which)
         0: begin parA = pattern[7:0]; reqA = 1'b1; end
         1: begin parB = pattern[7:0]; reqB = 1'b1; end
         default: begin parC = pattern; reqC = 1'b1; end
      endcase
      @(posedge sys_clk);
      #1;
      kCyc = cyc;
      reqA = 1'b0;
      reqB = 1'b0;
      reqC = 1'b0;
   endtask

   // Wait (bounded) for a data_valid strobe; a timeout counts as a failed comparison
   task automatic waitStrobe(input int which, input int budget, output int gotCyc);
      gotCyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge sys_clk);
         #1;
         if ((which == 0 && validA) || (which == 1 && validB) || (which == 2 && validC)) begin
            gotCyc = cyc;
            break;
         end
      end
      if (gotCyc < 0) begin
         total++;
         bad++;
         $display("[TB] FAIL strobeTimeout: got none want strobe within %0d cycles (dut %0d)", budget, which);
      end
   endtask

   // Main directed sequence
   initial begin
      int kCyc, v1, v2, v3, v4, snapA, snapB, snapC;

      vecs[0] = '{8'h5A, 8'h5A, 16'd1};
      vecs[1] = '{8'h01, 8'h01, 16'd2};
      vecs[2] = '{8'h80, 8'h80, 16'd3};
      vecs[3] = '{8'hFF, 8'hFF, 16'd4};
      vecs[4] = '{8'h00, 8'h00, 16'd5};

      // Reset values
      repeat (3) @(posedge sys_clk);
      #1;
      checkOutput("rstSck", {31'd0, sckB}, 32'd0);
      checkOutput("rstLoadN", {31'd0, loadNB}, 32'd1);
      checkOutput("rstCeN", {31'd0, ceNB}, 32'd1);
      checkOutput("rstData", {24'd0, doutB}, 32'd0);
      checkOutput("rstValid", {31'd0, validB}, 32'd0);
      checkOutput("rstBusy", {31'd0, busyB}, 32'd0);
      checkOutput("rstCount", {16'd0, cntB}, 32'd0);
      @(negedge sys_clk);
      reset = 1'b0;

      // Table-driven single reads on instance B (period 17*4+1 = 69)
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, {8'h00, vecs[i].pattern}, kCyc);
         waitStrobe(1, 200, v1);
         checkOutput($sformatf("vecLatency%0d", i), v1 - kCyc, 32'd69);
         checkOutput($sformatf("vecData%0d", i), {24'd0, doutB}, {24'd0, vecs[i].expData});
         checkOutput($sformatf("vecCount%0d", i), {16'd0, cntB}, {16'd0, vecs[i].expCount});
         @(posedge sys_clk);
         #1;
         checkOutput($sformatf("vecStrobeWidth%0d", i), {31'd0, validB}, 32'd0);
      end

      // Continuous polling with the chain inputs changing between loads
      @(negedge sys_clk);
      parB = 8'h00;
      reqB = 1'b1;
      waitStrobe(1, 200, v1);
      checkOutput("contData0", {24'd0, doutB}, 32'h00);
      parB = 8'hFF;
      waitStrobe(1, 200, v2);
      checkOutput("contData1", {24'd0, doutB}, 32'hFF);
      checkOutput("contSpacing1", v2 - v1, 32'd69);
      checkOutput("contNoIdle", {31'd0, busyB}, 32'd1);
      parB = 8'h3C;
      waitStrobe(1, 200, v3);
      checkOutput("contData2", {24'd0, doutB}, 32'h3C);
      checkOutput("contSpacing2", v3 - v2, 32'd69);
      reqB = 1'b0;
      waitStrobe(1, 200, v4);
      checkOutput("contCount", {16'd0, cntB}, 32'd9);
      repeat (3) @(posedge sys_clk);
      #1;
      checkOutput("contStops", {31'd0, busyB}, 32'd0);

      // Reset during SHIFT_HI of bit 3: that phase spans edges k+36..k+39
      applyStimulus(1, 16'h00C7, kCyc);
      repeat (37) @(posedge sys_clk);
      #1;
      checkOutput("midShiftSckHigh", {31'd0, sckB}, 32'd1);
      reset = 1'b1;
      snapB = strobesB;
      @(posedge sys_clk);
      #1;
      reset = 1'b0;
      checkOutput("midRstSck", {31'd0, sckB}, 32'd0);
      checkOutput("midRstLoadN", {31'd0, loadNB}, 32'd1);
      checkOutput("midRstCeN", {31'd0, ceNB}, 32'd1);
      checkOutput("midRstBusy", {31'd0, busyB}, 32'd0);
      checkOutput("midRstValid", {31'd0, validB}, 32'd0);
      repeat (120) @(posedge sys_clk);
      #1;
      checkOutput("midRstNoStrobe", strobesB - snapB, 32'd0);
      checkOutput("midRstCount", {16'd0, cntB}, 32'd0);

      // Request dropped during LOAD: read still completes, nothing follows
      @(negedge sys_clk);
      parB = 8'h69;
      reqB = 1'b1;
      @(posedge sys_clk);
      #1;
      snapA = loadLowsB;
      snapB = strobesB;
      repeat (2) @(posedge sys_clk);
      #1;
      reqB = 1'b0;
      waitStrobe(1, 200, v1);
      checkOutput("dropData", {24'd0, doutB}, 32'h69);
      repeat (150) @(posedge sys_clk);
      #1;
      checkOutput("dropLoadCycles", loadLowsB - snapA, 32'd4);
      checkOutput("dropStrobes", strobesB - snapB, 32'd1);
      checkOutput("dropIdle", {31'd0, busyB}, 32'd0);
      checkOutput("dropHold", {24'd0, doutB}, 32'h69);
      checkOutput("dropCount", {16'd0, cntB}, 32'd1);

      // read_count wrap from 0xFFFF
      @(negedge sys_clk);
      force dutB.count_q = 16'hFFFF;
      @(posedge sys_clk);
      #1;
      release dutB.count_q;
      @(posedge sys_clk);
      #1;
      checkOutput("wrapPreset", {16'd0, cntB}, 32'hFFFF);
      applyStimulus(1, 16'h00C3, kCyc);
      waitStrobe(1, 200, v1);
      checkOutput("wrapCount", {16'd0, cntB}, 32'h0000);
      checkOutput("wrapData", {24'd0, doutB}, 32'hC3);

      // Default configuration single read: latency 273, 7 sck rises, 16 load cycles
      snapA = sckRisesA;
      snapC = loadLowsA;
      applyStimulus(0, 16'h00A5, kCyc);
      waitStrobe(0, 400, v1);
      checkOutput("defLatency", v1 - kCyc, 32'd273);
      checkOutput("defData", {24'd0, doutA}, 32'hA5);
      checkOutput("defCount", {16'd0, cntA}, 32'd1);
      @(posedge sys_clk);
      #1;
      checkOutput("defStrobeWidth", {31'd0, validA}, 32'd0);
      checkOutput("defIdle", {31'd0, busyA}, 32'd0);
      checkOutput("defSckRises", sckRisesA - snapA, 32'd7);
      checkOutput("defLoadCycles", loadLowsA - snapC, 32'd16);

      // 16-bit chain, MSB-first ordering (period 33*4+1 = 133)
      snapC = sckRisesC;
      applyStimulus(2, 16'h8001, kCyc);
      waitStrobe(2, 300, v1);
      checkOutput("msbLatency", v1 - kCyc, 32'd133);
      checkOutput("msbData", {16'd0, doutC}, 32'h8001);
      checkOutput("msbFirstBit", {31'd0, doutC[15]}, 32'd1);
      checkOutput("msbSckRises", sckRisesC - snapC, 32'd15);
      applyStimulus(2, 16'h1234, kCyc);
      waitStrobe(2, 300, v1);
      checkOutput("msbData2", {16'd0, doutC}, 32'h1234);
      checkOutput("msbCount", {16'd0, cntC}, 32'd2);
      @(posedge sys_clk);
      #1;
      checkOutput("msbIdle", {31'd0, busyC}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
